// File: rtl/iir_inverse_fir_if.sv
// Stream bundle for the inverse first-order IIR stage: filtered samples and
// coefficient in, recovered samples out, valid/ready on both sides.
interface iir_inverse_fir_if #(
  parameter int W = 4
);
  logic [W-1:0] a;
  logic [W-1:0] y_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output a, y_in, in_valid, out_ready,
    input  in_ready, x_out, out_valid
  );

  modport slave (
    input  a, y_in, in_valid, out_ready,
    output in_ready, x_out, out_valid
  );
endinterface

// File: rtl/iir_inverse_fir.sv
// Recovers x[n] = y[n] - a*y[n-1] (mod 2^W) from a first-order recursive
// filter output, using a W-cycle sequential signed shift-add multiplier.
module iir_inverse_fir #(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  iir_inverse_fir_if.slave  bus
);
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {IDLE, MUL, OUT} state_e;

  state_e                state_q;
  logic signed [W-1:0]   y_prev_q;
  logic signed [W-1:0]   y_cur_q;
  logic signed [W-1:0]   a_lat_q;
  logic signed [W-1:0]   x_out_q;
  logic signed [2*W-1:0] acc_q;
  logic signed [2*W-1:0] acc_d;
  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] pp;
  logic [CNT_W-1:0]      cnt_q;
  logic                  out_valid_q;

  // Difference kept to the low W bits, matching the forward filter's wrap.
  function automatic logic signed [W-1:0] wrap_sub(
    input logic signed [W-1:0] lhs,
    input logic signed [W-1:0] rhs
  );
    logic signed [W:0] full;
    full = {lhs[W-1], lhs} - {rhs[W-1], rhs};
    return full[W-1:0];
  endfunction

  assign a_ext = {{W{a_lat_q[W-1]}}, a_lat_q};
  assign pp    = a_ext <<< cnt_q;

  // Baugh-Wooley: the multiplier sign bit carries weight -2^(W-1).
  always_comb begin
    acc_d = acc_q;
    if (y_prev_q[cnt_q]) begin
      if (cnt_q == LAST) acc_d = acc_q - pp;
      else               acc_d = acc_q + pp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      y_prev_q    <= '0;
      y_cur_q     <= '0;
      a_lat_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      x_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      y_prev_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            y_cur_q <= bus.y_in;
            a_lat_q <= bus.a;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            x_out_q     <= wrap_sub(y_cur_q, acc_d[W-1:0]);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        OUT: begin
          // History advances only once the recovered sample is taken.
          if (bus.out_ready) begin
            y_prev_q    <= y_cur_q;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_out_q;
endmodule

// File: tb/tb_iir_inverse_fir.sv
// Directed bench for iir_inverse_fir at W=4 with hand-computed expectations.
module tb_iir_inverse_fir;
  localparam int W = 4;

  logic clk;
  logic rst;
  logic clr;
  int   errs;
  int   checks;

  iir_inverse_fir_if #(.W(W)) bus ();

  iir_inverse_fir #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [W-1:0] y, input logic [W-1:0] a, input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
    bus.y_in     = y;
    bus.a        = a;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.out_valid && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'(W));
  endtask

  task automatic sample(input logic [W-1:0] y, input logic [W-1:0] a,
                        input logic [W-1:0] exp_x, input string tag);
    accept(y, a, tag);
    wait_out(tag);
    chk({tag, "_x"}, {28'd0, bus.x_out}, {28'd0, exp_x});
    chk({tag, "_rdy_lo"}, 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    errs          = 0;
    checks        = 0;
    rst           = 1'b1;
    clr           = 1'b0;
    bus.a         = '0;
    bus.y_in      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_x_out", {28'd0, bus.x_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // a=2: y=1,4,0xB -> x=1,2,3
    sample(4'h1, 4'h2, 4'h1, "a2_s0");
    sample(4'h4, 4'h2, 4'h2, "a2_s1");
    sample(4'hB, 4'h2, 4'h3, "a2_s2");

    // a=-1: y=3 -> 3, y=5 -> 5+3 = 8
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    sample(4'h3, 4'hF, 4'h3, "neg_s0");
    sample(4'h5, 4'hF, 4'h8, "neg_s1");

    // a=-8, y_prev=-8: product 0x40, low bits zero
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    sample(4'h8, 4'h3, 4'h8, "ext_s0");
    sample(4'h7, 4'h8, 4'h7, "ext_s1");

    // Backpressure: y_prev=7, y=2, a=1 -> 2-7 = 0xB
    bus.out_ready = 1'b0;
    accept(4'h2, 4'h1, "bp");
    wait_out("bp");
    bus.y_in     = 4'hF;
    bus.a        = 4'h7;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_x_hold", {28'd0, bus.x_out}, 32'hB);
      chk("bp_vld_hold", 32'(bus.out_valid), 32'd1);
      chk("bp_rdy_lo", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", 32'(bus.out_valid), 32'd0);
    // y_prev must now be 2: y=5, a=1 -> 3
    sample(4'h5, 4'h1, 4'h3, "bp_next");

    // clr during MUL discards the sample and history
    accept(4'h9, 4'h3, "clr");
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("clr_no_pulse", 32'(seen), 32'd0);
    sample(4'h6, 4'h3, 4'h6, "clr_next");

    // rst during MUL: outputs go to reset values without a clock edge
    accept(4'h1, 4'h1, "rstm");
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstm_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstm_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    sample(4'h3, 4'h5, 4'h3, "rstm_next");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
